// File: rtl/prime_nth_ctrl.sv
// prime_nth_ctrl: shares one primegen between NREQ requesters, each asking
// for the n-th value of the generator sequence. Tracks the generator's
// current index, steps forward or rewinds as needed, round-robin grants.
// Optional feature macro: PRIME_NTH_TIMEOUT_EN (per-step pg_ready watchdog).
module prime_nth_ctrl #(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*IDX_W-1:0] idx,
  output logic [NREQ-1:0]       done,
  output logic [15:0]           res_out,
  output logic                  err_out,
  output logic                  busy,
  output logic                  pg_go,
  output logic                  pg_rst,
  input  logic                  pg_ready,
  input  logic                  pg_error,
  input  logic [15:0]           pg_res
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_PG_RST, S_WAIT_RDY, S_IDLE, S_CMP, S_GO, S_FALL, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [NREQ-1:0]            pend_q, pend_d;
  logic [NREQ-1:0][IDX_W-1:0] idx_q, idx_d;
  logic [PW-1:0]              rr_q, rr_d;
  logic [PW-1:0]              gnt_q, gnt_d;
  logic [IDX_W:0]             cur_q, cur_d;
  logic                       dirty_q, dirty_d;
  logic                       init_q, init_d;
  logic                       busy_q, busy_d;
  logic [15:0]                res_q, res_d;
  logic                       err_q, err_d;

  logic                       pick_vld;
  logic [PW-1:0]              pick;
  logic [IDX_W:0]             tgt;
  logic [PW-1:0]              gnt_next;
  logic                       to_hit;

`ifdef PRIME_NTH_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);
  logic [15:0] wdog_q, wdog_d;

  // Watchdog: counts cycles spent in FALL/WAIT_RDY, cleared on any state exit
  always_comb begin
    wdog_d = '0;
    if ((state_q == S_FALL || state_q == S_WAIT_RDY) && state_d == state_q)
      wdog_d = wdog_q + 16'd1;
  end

  // Watchdog register
  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  assign to_hit = (wdog_q == TO_LIM);
`else
  // No watchdog in this build; TIMEOUT is never negative so this stays 0
  assign to_hit = (TIMEOUT < 0);
`endif

  // Round-robin pick: lowest pending index at or after rr_q, wrapping
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_q;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_vld && pend_q[j]) begin
        pick_vld = 1'b1;
        pick     = PW'(j);
      end
    end
  end

  assign tgt      = {1'b0, idx_q[gnt_q]};
  assign gnt_next = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);

  // Request capture: a req is taken when nothing is pending for that slot,
  // or when the slot's done pulse frees it in the same cycle
  always_comb begin
    pend_d = pend_q;
    idx_d  = idx_q;
    for (int i = 0; i < NREQ; i++) begin
      if (done[i]) pend_d[i] = 1'b0;
      if (req[i] && (!pend_q[i] || done[i])) begin
        pend_d[i] = 1'b1;
        idx_d[i]  = idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // Next-state logic for the primegen sequencing FSM
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dirty_d = dirty_q;
    init_d  = init_q;
    busy_d  = busy_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      S_PG_RST: begin
        cur_d   = '0;
        dirty_d = 1'b0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (init_q) begin
          if (pg_ready) begin
            init_d  = 1'b0;
            state_d = S_IDLE;
          end else if (to_hit) begin
            state_d = S_PG_RST;
          end
        end else if (pg_error) begin
          res_d   = pg_res;
          err_d   = 1'b1;
          dirty_d = 1'b1;
          state_d = S_DONE;
        end else if (pg_ready) begin
          state_d = S_CMP;
        end else if (to_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          dirty_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          busy_d  = 1'b1;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        // A dirty generator is rewound before its error flag is trusted again
        if (dirty_q) begin
          state_d = S_PG_RST;
        end else if (pg_error) begin
          res_d   = pg_res;
          err_d   = 1'b1;
          dirty_d = 1'b1;
          state_d = S_DONE;
        end else if (tgt == cur_q && pg_ready) begin
          res_d   = pg_res;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (tgt < cur_q) begin
          state_d = S_PG_RST;
        end else begin
          state_d = S_GO;
        end
      end
      S_GO: state_d = S_FALL;
      S_FALL: begin
        if (!pg_ready) begin
          cur_d   = cur_q + 1'b1;
          state_d = S_WAIT_RDY;
        end else if (to_hit) begin
          res_d   = '0;
          err_d   = 1'b1;
          dirty_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rr_d    = gnt_next;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_PG_RST;
    endcase
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PG_RST;
      pend_q  <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      cur_q   <= '0;
      dirty_q <= 1'b0;
      init_q  <= 1'b1;
      busy_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cur_q   <= cur_d;
      dirty_q <= dirty_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Output decode; reset forces everything low except the primegen reset
  always_comb begin
    done    = '0;
    if (state_q == S_DONE && !rst) done = NREQ'(1) << gnt_q;
    res_out = rst ? 16'd0 : res_q;
    err_out = err_q & ~rst;
    busy    = busy_q & ~rst;
    pg_go   = (state_q == S_GO) & ~rst;
    pg_rst  = rst | (state_q == S_PG_RST);
  end

endmodule

// File: tb/tb_prime_nth_ctrl.sv
// Bench for prime_nth_ctrl: behavioural primegen, scoreboard + monitor.
module tb_prime_nth_ctrl;
  localparam int NREQ  = 4;
  localparam int IDX_W = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*IDX_W-1:0] idx = '0;
  logic [NREQ-1:0]       done;
  logic [15:0]           res_out;
  logic                  err_out, busy, pg_go, pg_rst;
  logic                  pg_ready, pg_error;
  logic [15:0]           pg_res;

  prime_nth_ctrl #(.NREQ(NREQ), .IDX_W(IDX_W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .idx(idx), .done(done),
    .res_out(res_out), .err_out(err_out), .busy(busy), .pg_go(pg_go),
    .pg_rst(pg_rst), .pg_ready(pg_ready), .pg_error(pg_error), .pg_res(pg_res)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int go_cnt = 0;
  int prst_cnt = 0;
  int last_done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- primegen model ----------------
  function automatic bit is_prime(input int v);
    if (v < 2) return 0;
    for (int d = 2; d * d <= v; d++) if (v % d == 0) return 0;
    return 1;
  endfunction

  function automatic logic [15:0] prime_at(input int n);
    int c, v;
    if (n == 0) return 16'd1;
    c = 0; v = 1;
    while (c < n) begin
      v++;
      if (is_prime(v)) c++;
    end
    return 16'(v);
  endfunction

  int   m_step = 0;
  int   m_cnt  = 0;
  bit   m_busy = 0;
  bit   m_hang = 0;
  int   err_step = 1000;
  logic m_ready = 0, m_err = 0;
  logic [15:0] m_res = '0;

  assign pg_ready = m_ready;
  assign pg_error = m_err;
  assign pg_res   = m_res;

  always @(posedge clk) begin
    if (pg_rst) begin
      m_step <= 0; m_ready <= 0; m_err <= 0; m_res <= '0; m_busy <= 1; m_cnt <= 2;
    end else if (pg_go) begin
      m_step <= m_step + 1; m_ready <= 0; m_err <= 0; m_busy <= 1; m_cnt <= 3;
    end else if (m_busy && !m_hang) begin
      if (m_cnt == 0) begin
        m_ready <= 1; m_busy <= 0; m_res <= prime_at(m_step);
        m_err <= (m_step == err_step);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          who;
    logic [15:0] res;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Monitor: pops one expectation per done pulse, counts primegen handshakes
  always @(negedge clk) begin
    if (!rst) begin
      if (pg_go)  go_cnt++;
      if (pg_rst) prst_cnt++;
      if (done != '0) begin
        last_done_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_vec", 32'(done), 32'(NREQ'(1) << e.who));
          chk("res_out",  32'(res_out), 32'(e.res));
          chk("err_out",  32'(err_out), 32'(e.err));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int req_cyc = 0;

  task automatic push(input int who, input logic [15:0] r, input logic e);
    exp_t x;
    x.who = who; x.res = r; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic issue(input int r0, input int v0, input int r1, input int v1);
    @(negedge clk);
    req = '0;
    req[r0] = 1'b1; idx[r0*IDX_W +: IDX_W] = IDX_W'(v0);
    if (r1 >= 0) begin
      req[r1] = 1'b1; idx[r1*IDX_W +: IDX_W] = IDX_W'(v1);
    end
    req_cyc = cyc;
    @(negedge clk);
    req = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout pending=%0d required=0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  int g0, r0;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pg_rst", 32'(pg_rst), 32'd1);
    chk("rst_pg_go",  32'(pg_go),  32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_res",    32'(res_out), 32'd0);
    chk("rst_err",    32'(err_out), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Forward from 0 to index 5
    g0 = go_cnt; r0 = prst_cnt;
    push(0, 16'd11, 1'b0);
    issue(0, 5, -1, 0);
    drain("t1", 500);
    chk("t1_go", 32'(go_cnt - g0), 32'd5);
    chk("t1_rst", 32'(prst_cnt - r0), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);

    // Forward from 5 to 11
    g0 = go_cnt; r0 = prst_cnt;
    push(1, 16'd31, 1'b0);
    issue(1, 11, -1, 0);
    drain("t2", 500);
    chk("t2_go", 32'(go_cnt - g0), 32'd6);
    chk("t2_rst", 32'(prst_cnt - r0), 32'd0);

    // Rewind to 3
    g0 = go_cnt; r0 = prst_cnt;
    push(2, 16'd5, 1'b0);
    issue(2, 3, -1, 0);
    drain("t3", 500);
    chk("t3_go", 32'(go_cnt - g0), 32'd3);
    chk("t3_rst", 32'(prst_cnt - r0), 32'd1);

    // Hit on requester 0 leaves rr_ptr at 1
    g0 = go_cnt;
    push(0, 16'd5, 1'b0);
    issue(0, 3, -1, 0);
    drain("t3b", 100);
    chk("t3b_go", 32'(go_cnt - g0), 32'd0);

    // Simultaneous requests: 3 then 0
    push(3, 16'd3, 1'b0);
    push(0, 16'd7, 1'b0);
    issue(0, 4, 3, 2);
    drain("t4", 800);
    chk("t4_rr", 32'(dut.rr_q), 32'd1);

    // Generator error at step 7, then recovery via rewind
    err_step = 7;
    push(1, 16'd17, 1'b1);
    issue(1, 9, -1, 0);
    drain("t5", 500);
    err_step = 1000;
    g0 = go_cnt; r0 = prst_cnt;
    push(2, 16'd3, 1'b0);
    issue(2, 2, -1, 0);
    drain("t5b", 500);
    chk("t5b_rst", 32'(prst_cnt - r0), 32'd1);
    chk("t5b_go", 32'(go_cnt - g0), 32'd2);

    // Reset in the middle of a request
    issue(0, 20, -1, 0);
    begin
      int n = 0;
      while (!pg_go && n < 200) begin @(negedge clk); n++; end
      chk("t6_go_seen", 32'(pg_go), 32'd1);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_pg_rst", 32'(pg_rst), 32'd1);
    chk("t6_done",   32'(done), 32'd0);
    chk("t6_pend",   32'(dut.pend_q), 32'd0);
    chk("t6_busy",   32'(busy), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    push(0, 16'd1, 1'b0);
    issue(0, 0, -1, 0);
    drain("t6b", 100);
    chk("t6b_latency", 32'(last_done_cyc - req_cyc), 32'd3);

`ifdef PRIME_NTH_TIMEOUT_EN
    // Generator that never becomes ready again
    m_hang = 1;
    push(3, 16'd0, 1'b1);
    issue(3, 1, -1, 0);
    drain("t7", 400);
    m_hang = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t limit=2000000", $time);
    $fatal(1, "timeout");
  end

endmodule
